// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: FSM encoding, frame sizes, scan-code prefixes.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package ps2_pkg;

   // Receiver FSM state encoding
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_e;

   localparam int PS2_DATA_BITS = 8;

   // Scan-code prefixes, also decoded by the keyboard-matrix mapper
   localparam logic [7:0] PS2_EXTENDED = 8'hE0;
   localparam logic [7:0] PS2_RELEASE  = 8'hF0;

   // A frame is good when the stop bit is high and data plus parity has odd weight
   function automatic logic ps2_frame_ok(input logic [PS2_DATA_BITS-1:0] dat,
                                         input logic                     par,
                                         input logic                     stp);
      return stp & (^{dat, par});
   endfunction

endpackage

// File: rtl/ps2_filter.sv
// Synchronizes the raw PS/2 clock pin and debounces it with a FILTER_LEN-deep majority-free filter.
// Latency: filtered fall pulse FILTER_LEN+3 clk edges after the pin is first sampled low.
// Backpressure: none; free-running, one-cycle fall pulse.
module ps2_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic fall
);

   logic                  sync1_q, sync1_d;
   logic                  sync2_q, sync2_d;
   logic [FILTER_LEN-1:0] shift_q, shift_d;
   logic                  level_q, level_d;
   logic                  fall_q,  fall_d;

   // Next-state: shift in the synchronized level, change filtered level only on unanimous history
   always_comb begin
      sync1_d = din;
      sync2_d = sync1_q;
      shift_d = {shift_q[FILTER_LEN-2:0], sync2_q};
      level_d = level_q;
      if (&shift_q) begin
         level_d = 1'b1;
      end else if (~|shift_q) begin
         level_d = 1'b0;
      end
      // Registered alongside the level so the pulse lines up with the new low level
      fall_d = level_q & ~level_d;
   end

   // State registers; everything resets to the idle-high bus level
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         shift_q <= '1;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         shift_q <= shift_d;
         level_q <= level_d;
         fall_q  <= fall_d;
      end
   end

   assign fall = fall_q;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: deframes start/8 data/odd parity/stop and emits one result pulse per frame.
// Latency: valid/error registered FILTER_LEN+4 clk edges after the stop-bit clock fall is first sampled.
// Backpressure: none; valid/error are single-cycle pulses and data holds until the next good frame.
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 40000
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     ps2_clk,
   input  logic                     ps2_data,
   output logic [PS2_DATA_BITS-1:0] data,
   output logic                     valid,
   output logic                     error
);

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
   localparam logic [2:0]  BIT_LAST = 3'(PS2_DATA_BITS - 1);

   logic                     clk_fall;
   logic                     dsync1_q, dsync1_d;
   logic                     dsync2_q, dsync2_d;
   ps2_state_e               state_q, state_d;
   logic [2:0]               bit_cnt_q, bit_cnt_d;
   logic [PS2_DATA_BITS-1:0] shreg_q, shreg_d;
   logic                     parity_q, parity_d;
   logic [15:0]              tmo_q, tmo_d;
   logic [PS2_DATA_BITS-1:0] data_q, data_d;
   logic                     valid_q, valid_d;
   logic                     error_q, error_d;
   logic                     tmo_hit;

   // Debounced PS/2 clock, only its falling edge is of interest
   ps2_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_clk_filt (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (ps2_clk),
      .fall    (clk_fall)
   );

   // Plain two-flop synchronizer for the data pin
   always_comb begin
      dsync1_d = ps2_data;
      dsync2_d = dsync1_q;
   end

   // Frame FSM: sample data on each filtered fall; timeout aborts only when no edge arrives
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      parity_d  = parity_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      error_d   = 1'b0;
      tmo_d     = (state_q == ST_IDLE) ? 16'd0 : tmo_q + 16'd1;
      tmo_hit   = (state_q != ST_IDLE) && (tmo_q == TMO_LAST);

      if (clk_fall) begin
         tmo_d = 16'd0;
         unique case (state_q)
            ST_IDLE: begin
               // A high sample here is line noise or a lost frame tail; ignore it silently
               if (!dsync2_q) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            ST_DATA: begin
               shreg_d   = {dsync2_q, shreg_q[PS2_DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == BIT_LAST) begin
                  state_d = ST_PARITY;
               end
            end
            ST_PARITY: begin
               parity_d = dsync2_q;
               state_d  = ST_STOP;
            end
            ST_STOP: begin
               if (ps2_frame_ok(shreg_q, parity_q, dsync2_q)) begin
                  data_d  = shreg_q;
                  valid_d = 1'b1;
               end else begin
                  error_d = 1'b1;
               end
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (tmo_hit) begin
         error_d   = 1'b1;
         state_d   = ST_IDLE;
         bit_cnt_d = 3'd0;
         tmo_d     = 16'd0;
      end
   end

   // State registers; reset clears outputs and returns to IDLE even mid-frame
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dsync1_q  <= 1'b1;
         dsync2_q  <= 1'b1;
         state_q   <= ST_IDLE;
         bit_cnt_q <= 3'd0;
         shreg_q   <= '0;
         parity_q  <= 1'b0;
         tmo_q     <= 16'd0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         dsync1_q  <= dsync1_d;
         dsync2_q  <= dsync2_d;
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         parity_q  <= parity_d;
         tmo_q     <= tmo_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         error_q   <= error_d;
      end
   end

   assign data  = data_q;
   assign valid = valid_q;
   assign error = error_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed self-checking bench for ps2_rx with short filter and timeout values.
// Latency: expectations are FILTER_LEN+4 cycles per result and FILTER_LEN+4+TIMEOUT for a timeout.
// Backpressure: n/a.
module tb_ps2_rx;

   localparam int FLEN = 8;
   localparam int TMO  = 200;
   localparam int HALF = 20;       // PS/2 half bit period in clk cycles
   localparam int LAT  = FLEN + 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] data;
   logic       valid;
   logic       error;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int valid_cnt = 0, error_cnt = 0, both_cnt = 0;
   int valid_cyc = 0, error_cyc = 0;
   int last_fall_cyc = 0;
   int v0, e0;

   ps2_rx #(
      .FILTER_LEN (FLEN),
      .TIMEOUT    (TMO)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .data     (data),
      .valid    (valid),
      .error    (error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Pulse monitor, sampled on the opposite edge
   always @(negedge clk) begin
      if (valid) begin
         valid_cnt++;
         valid_cyc = cyc;
      end
      if (error) begin
         error_cnt++;
         error_cyc = cyc;
      end
      if (valid && error) both_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Sends the first nbits of a frame, bit 0 (start) first
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int nbits);
      logic [10:0] f;
      f = {stp, par, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         wait_cycles(HALF);
         ps2_clk = 1'b0;
         last_fall_cyc = cyc;
         wait_cycles(HALF);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic snap();
      v0 = valid_cnt;
      e0 = error_cnt;
   endtask

   initial begin
      reset_n  = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      wait_cycles(4);
      chk("rst_data",  32'(data),  32'h00);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_error", 32'(error), 32'h0);
      reset_n = 1'b1;
      wait_cycles(5);

      // Good frame 0x1C, odd parity bit 0
      snap();
      send_frame(8'h1C, 1'b0, 1'b1, 11);
      wait_cycles(10);
      chk("1c_valid_cnt", 32'(valid_cnt - v0), 32'd1);
      chk("1c_error_cnt", 32'(error_cnt - e0), 32'd0);
      chk("1c_data",      32'(data), 32'h1C);
      chk("1c_latency",   32'(valid_cyc - last_fall_cyc), 32'(LAT));

      // Bad parity on 0xF0
      snap();
      send_frame(8'hF0, 1'b0, 1'b1, 11);
      wait_cycles(10);
      chk("par_error_cnt", 32'(error_cnt - e0), 32'd1);
      chk("par_valid_cnt", 32'(valid_cnt - v0), 32'd0);
      chk("par_data",      32'(data), 32'h1C);
      chk("par_latency",   32'(error_cyc - last_fall_cyc), 32'(LAT));

      // Bad stop bit on 0x29 with correct parity
      snap();
      send_frame(8'h29, 1'b0, 1'b0, 11);
      wait_cycles(10);
      chk("stop_error_cnt", 32'(error_cnt - e0), 32'd1);
      chk("stop_valid_cnt", 32'(valid_cnt - v0), 32'd0);
      chk("stop_data",      32'(data), 32'h1C);

      // Seven-cycle low glitch while idle with data low must not start a frame
      snap();
      ps2_data = 1'b0;
      ps2_clk  = 1'b0;
      wait_cycles(FLEN - 1);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      wait_cycles(30);
      chk("glitch_pulses", 32'((valid_cnt - v0) + (error_cnt - e0)), 32'd0);
      snap();
      send_frame(8'h5A, 1'b1, 1'b1, 11);
      wait_cycles(10);
      chk("5a_valid_cnt", 32'(valid_cnt - v0), 32'd1);
      chk("5a_error_cnt", 32'(error_cnt - e0), 32'd0);
      chk("5a_data",      32'(data), 32'h5A);

      // Start plus three data bits, then silence: timeout TMO cycles after the last fall is consumed
      snap();
      send_frame(8'h07, 1'b0, 1'b1, 4);
      wait_cycles(TMO + 40);
      chk("tmo_error_cnt", 32'(error_cnt - e0), 32'd1);
      chk("tmo_valid_cnt", 32'(valid_cnt - v0), 32'd0);
      chk("tmo_latency",   32'(error_cyc - last_fall_cyc), 32'(LAT + TMO));
      chk("tmo_data",      32'(data), 32'h5A);
      snap();
      send_frame(8'h12, 1'b1, 1'b1, 11);
      wait_cycles(10);
      chk("12_valid_cnt", 32'(valid_cnt - v0), 32'd1);
      chk("12_error_cnt", 32'(error_cnt - e0), 32'd0);
      chk("12_data",      32'(data), 32'h12);

      // Asynchronous reset after five data bits
      send_frame(8'hFF, 1'b1, 1'b1, 6);
      #3;
      reset_n = 1'b0;
      #1;
      chk("arst_data",  32'(data),  32'h00);
      chk("arst_valid", 32'(valid), 32'h0);
      chk("arst_error", 32'(error), 32'h0);
      wait_cycles(3);
      reset_n = 1'b1;
      wait_cycles(5);
      snap();
      send_frame(8'hE0, 1'b0, 1'b1, 11);
      wait_cycles(10);
      chk("e0_valid_cnt", 32'(valid_cnt - v0), 32'd1);
      chk("e0_error_cnt", 32'(error_cnt - e0), 32'd0);
      chk("e0_data",      32'(data), 32'hE0);

      chk("valid_and_error", 32'(both_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ps2_rx.md
# ps2_rx

PS/2 device-to-host serial receiver for the keyboard path. It samples the raw PS/2 clock and data pins in the system clock domain and debounces the clock line. It deframes the 11-bit PS/2 frame (start, 8 data LSB-first, odd parity, stop) and delivers each scan-code byte with a one-cycle `valid` or `error` pulse. It sits directly upstream of the keyboard-matrix mapper, which consumes `data`/`valid` to track E0/F0 prefixes and update the KA/KD matrix.

## Interface
- `FILTER_LEN`, default 8: number of consecutive identical synchronized samples needed to change the filtered PS/2 clock level (range 2..32).
- `TIMEOUT`, default 40000: number of clk cycles without a filtered falling edge, while inside a frame, before the frame is aborted (range 16..65535).
- `clk`  in  1: system clock; the only clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `ps2_clk`  in  1: raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1: raw PS/2 data pin, asynchronous.
- `data`  out  8: last correctly received byte; held until the next good frame.
- `valid`  out  1: one-cycle pulse; `data` is new this cycle.
- `error`  out  1: one-cycle pulse on parity, stop or timeout failure.

## Operation
- **Synchronizers.** `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer. Both reset to 1 (idle bus level).
- **Clock filter.**
  - A FILTER_LEN-bit shift register holds the synchronized clock.
  - The filtered clock goes to 0 when all bits are 0, goes to 1 when all bits are 1, and holds otherwise.
  - The shift register and filtered clock reset to all ones.
  - A filtered falling edge is filtered clock previous = 1 and current = 0.
- **Sampling.** On each filtered falling edge, the synchronized data bit is sampled.
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge with data = 0, go to DATA and clear the bit count. An edge with data = 1 is ignored and raises no error.
  - DATA: shift the sample into bit 7 of the shift register (LSB arrives first). After the 8th bit, go to PARITY.
  - PARITY: latch the parity bit, then go to STOP.
  - STOP: on the edge, the frame is good if the stop bit = 1 and the XOR of the 8 data bits and the parity bit = 1. A good frame loads `data` and pulses `valid`; a bad frame pulses `error` and leaves `data` unchanged. Return to IDLE in both cases.
- **Timeout.**
  - A 16-bit counter runs in every state except IDLE and clears on each filtered falling edge.
  - When the counter reaches TIMEOUT-1: pulse `error`, go to IDLE, and clear the bit count.
  - If a timeout and a filtered edge occur in the same cycle, the edge wins and the counter clears.
- **Output rules.**
  - `valid` and `error` are never high together.
  - Each is high for exactly one cycle per frame, and at most one frame result is produced per frame.
- **Scope.** No host-to-device transmission; the block never drives the pins.
- **Reset.** Asserting `reset_n` at any time, including mid-frame, immediately sets `data` = 0x00, `valid` = 0, `error` = 0, FSM = IDLE, counters = 0. The first frame after release is received normally.

## Timing
- Edge 1 is the first clk edge that samples `ps2_clk` low, with the pin stable afterwards. The filtered edge is detected at edge FILTER_LEN+3; the FSM acts and `valid`/`error` go high after edge FILTER_LEN+4, for one cycle.
- Data is sampled FILTER_LEN+2 cycles after the clock falls. The requirement FILTER_LEN+4 < half a PS/2 bit period (≥ 30 µs) therefore holds for any clk ≥ 2 MHz.
- Low glitches on `ps2_clk` shorter than FILTER_LEN cycles produce no edge.
- Back-to-back frames: the next start bit may arrive on the PS/2 clock edge right after the stop bit; no dead time is required.

## Structure
- Package `ps2_pkg`:
  - FSM state encoding (2 bits).
  - `PS2_DATA_BITS = 8`.
  - Scan-code prefix constants `PS2_EXTENDED = 8'hE0` and `PS2_RELEASE = 8'hF0`, shared with the matrix mapper.
- Sub-module `ps2_filter`: 2-flop synchronizer plus the FILTER_LEN-deep glitch filter, with `fall` edge-pulse output. It is instantiated once, for `ps2_clk`. `ps2_data` uses a plain 2-flop synchronizer only.

## Test plan
- Send frame 0x1C with parity 0 and stop 1 → one `valid` pulse FILTER_LEN+4 cycles after the stop-bit clock fall; `data` = 0x1C; `error` stays 0.
- Send 0xF0 with parity 0 (wrong; correct is 1) → one `error` pulse, no `valid`; `data` stays 0x1C.
- Send 0x29 (parity 0) with stop bit 0 → `error` pulse; `data` unchanged.
- With FILTER_LEN = 8 and IDLE, apply a 7-cycle low glitch on `ps2_clk` with `ps2_data` = 0 → no state change, no pulses. Then send 0x5A (parity 1) → `valid`, `data` = 0x5A.
- Send start plus 3 data bits, then hold `ps2_clk` high → `error` pulse exactly TIMEOUT cycles after the last fall. A following frame 0x12 (parity 1) → `valid`, `data` = 0x12.
- Assert `reset_n` low after 5 data bits of a frame → outputs 0 asynchronously. After release, send 0xE0 (parity 0) → `valid`, `data` = 0xE0.
